// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the two-stage ALU pipeline.
// Opcode encodings are shared by the datapath and the pipeline top.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_ACC = 3'b110,
    OP_CLR = 3'b111
  } op_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result, carry/borrow and the next accumulator.
// Carry falls out of a WIDTH+1 bit add, subtract or shift.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] acc_sum;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign acc_sum = {1'b0, acc} + {1'b0, a};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    acc_next = acc;
    unique case (op)
      OP_ADD: {carry, result} = sum;
      OP_SUB: {carry, result} = diff;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: {carry, result} = {a, 1'b0};
      OP_ACC: begin
        {carry, result} = acc_sum;
        acc_next        = acc_sum[WIDTH-1:0];
      end
      OP_CLR: acc_next = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshakes on both sides.
// acc commits only when an op moves S1 -> S2, so ACC ops chain freely.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_t              s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] acc;
  logic             adv;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic [WIDTH-1:0] core_acc;

  assign adv       = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv;
  assign out_valid = s2_valid;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a        (s1_a),
    .b        (s1_b),
    .acc      (acc),
    .op       (s1_op),
    .result   (core_result),
    .carry    (core_carry),
    .acc_next (core_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s2_valid <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      acc      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= a;
          s1_b  <= b;
          s1_op <= op_t'(op);
        end
      end
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= core_result;
          carry  <= core_carry;
          zero   <= (core_result == '0);
          acc    <= core_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, stall/reset sequences, random run.
// A queue-based reference model scores every output transfer in order.
module tb_alu_pipe;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: arithmetic on plain ints, acc applied in op order
  typedef struct {
    int res;
    int cy;
  } exp_t;

  exp_t q[$];
  int   macc = 0;

  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    e.res = 0;
    e.cy  = 0;
    case (o)
      0: begin e.res = (x + y) % M; e.cy = (x + y >= M) ? 1 : 0; end
      1: begin e.res = (x - y + M) % M; e.cy = (x < y) ? 1 : 0; end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: begin e.res = (2 * x) % M; e.cy = (x >= M / 2) ? 1 : 0; end
      6: begin
        e.cy  = (macc + x >= M) ? 1 : 0;
        macc  = (macc + x) % M;
        e.res = macc;
      end
      default: begin macc = 0; e.res = 0; end
    endcase
    return e;
  endfunction

  logic [W-1:0] held_r;
  logic         held_c;
  logic         held_z;
  bit           stalled = 1'b0;

  // Scoreboard: inputs are stable here, so transfers at the next edge are known
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      macc    = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_result", 32'(result), 32'(held_r));
        chk("stall_carry", 32'(carry), 32'(held_c));
        chk("stall_zero", 32'(zero), 32'(held_z));
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got unexpected result 0x%0h", result);
        end else begin
          e = q.pop_front();
          chk("sb_result", 32'(result), e.res);
          chk("sb_carry", 32'(carry), e.cy);
          chk("sb_zero", 32'(zero), (e.res == 0) ? 1 : 0);
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held_r  = result;
        held_c  = carry;
        held_z  = zero;
      end
      if (in_valid && in_ready)
        q.push_back(model(32'(op), 32'(a), 32'(b)));
    end
  end

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 200) begin
      step();
      t++;
    end
    chk("drain_in_time", (t < 200) ? 1 : 0, 1);
  endtask

  typedef struct {
    int op;
    int a;
    int b;
    int r;
    int c;
  } vec_t;

  vec_t tv[10];
  vec_t sv[4];
  int   acc_n;
  bit   ok;

  initial begin
    tv[0] = '{0, 'hFF, 'h01, 'h00, 1};
    tv[1] = '{1, 'h03, 'h05, 'hFE, 1};
    tv[2] = '{5, 'h81, 'h00, 'h02, 1};
    tv[3] = '{2, 'hF0, 'h3C, 'h30, 0};
    tv[4] = '{3, 'hF0, 'h0C, 'hFC, 0};
    tv[5] = '{4, 'hFF, 'h0F, 'hF0, 0};
    tv[6] = '{0, 'h7F, 'h01, 'h80, 0};
    tv[7] = '{7, 'h55, 'hAA, 'h00, 0};
    tv[8] = '{6, 'h10, 'h00, 'h10, 0};
    tv[9] = '{1, 'h05, 'h05, 'h00, 0};
    sv[0] = '{0, 'h12, 'h34, 0, 0};
    sv[1] = '{4, 'hAA, 'h55, 0, 0};
    sv[2] = '{1, 'h10, 'h20, 0, 0};
    sv[3] = '{5, 'h40, 'h00, 0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    in_valid  = 1'b1;
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_zero", 32'(zero), 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Directed vectors, one op at a time, result two edges later
    for (int i = 0; i < 10; i++) begin
      op       = tv[i].op[2:0];
      a        = tv[i].a[W-1:0];
      b        = tv[i].b[W-1:0];
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_result", i), 32'(result), tv[i].r);
      chk($sformatf("vec%0d_carry", i), 32'(carry), tv[i].c);
      chk($sformatf("vec%0d_zero", i), 32'(zero),
          (tv[i].r == 0) ? 1 : 0);
    end
    step();

    // CLR then three back-to-back ACC 0x10
    in_valid = 1'b1;
    op       = 3'b111;
    step();
    op = 3'b110;
    a  = 8'h10;
    step();
    chk("chain_clr", 32'(result), 0);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) in_valid = 1'b0;
      step();
      chk($sformatf("chain_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("chain_acc%0d", k), 32'(result), 16 * k);
    end
    drain();

    // Four ops against a stalled consumer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_n     = 0;
    for (int c = 0; c < 6; c++) begin
      op = sv[acc_n].op[2:0];
      a  = sv[acc_n].a[W-1:0];
      b  = sv[acc_n].b[W-1:0];
      ok = in_ready;
      step();
      if (ok) acc_n++;
    end
    chk("stall_accepted", acc_n, 2);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc_n < 4; c++) begin
      op = sv[acc_n].op[2:0];
      a  = sv[acc_n].a[W-1:0];
      b  = sv[acc_n].b[W-1:0];
      ok = in_ready;
      step();
      if (ok) acc_n++;
    end
    in_valid = 1'b0;
    chk("stall_all_accepted", acc_n, 4);
    drain();

    // Reset with two ACC ops in flight
    in_valid = 1'b1;
    op       = 3'b110;
    a        = 8'h21;
    step();
    a = 8'h22;
    step();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    chk("midrst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    op       = 3'b110;
    a        = 8'h07;
    step();
    in_valid = 1'b0;
    step();
    chk("midrst_acc_valid", 32'(out_valid), 1);
    chk("midrst_acc_result", 32'(result), 7);
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
